// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the raw PS/2 pins,
// deserializes 11-bit device-to-host frames, and tracks the currently held
// key (make / break / E0-extended) for the video controller.
module ps2_key_decoder #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DAT,
    output logic [7:0] oBYTE,
    output logic       oBYTE_VALID,
    output logic       oFRAME_ERR,
    output logic [7:0] oKEY_CODE,
    output logic       oKEY_EXT
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    logic         clk_meta, clk_sync;
    logic         dat_meta, dat_sync;
    logic         clk_filt;
    logic [7:0]   filt_cnt;
    logic         fall_strobe;

    state_t       state;
    logic [2:0]   bit_cnt;
    logic [7:0]   shift;
    logic         par_bit;
    logic [TW-1:0] tmo_cnt;

    logic         ext_pend;
    logic         brk_pend;

    // Two-flop synchronizers for both pins; idle level of the bus is high.
    always_ff @(posedge iCLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value of its neighbour, giving a real 2-stage chain.
        if (iRST) begin
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
        end else begin
            clk_meta <= iPS2_CLK;
            clk_sync <= clk_meta;
            dat_meta <= iPS2_DAT;
            dat_sync <= dat_meta;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_sync == clk_filt) begin
            filt_cnt <= '0;
        end else if (filt_cnt == 8'(FILTER_LEN - 1)) begin
            clk_filt <= clk_sync;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end

    // Strobe is high in the very cycle the filtered clock takes the 1->0 step.
    assign fall_strobe = clk_filt && !clk_sync && (filt_cnt == 8'(FILTER_LEN - 1));

    // Frame FSM with timeout and registered byte / error strobes.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift       <= '0;
            par_bit     <= 1'b0;
            tmo_cnt     <= '0;
            oBYTE       <= '0;
            oBYTE_VALID <= 1'b0;
            oFRAME_ERR  <= 1'b0;
        end else begin
            // NOTE: strobes get a default here and are overridden below; the
            // last non-blocking assignment in the block wins.
            oBYTE_VALID <= 1'b0;
            oFRAME_ERR  <= 1'b0;

            if (state == IDLE || fall_strobe) begin
                tmo_cnt <= '0;
            end else begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (fall_strobe && !dat_sync) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (fall_strobe) begin
                        shift   <= {dat_sync, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (fall_strobe) begin
                        par_bit <= dat_sync;
                        state   <= STOP;
                    end
                end
                STOP: begin
                    if (fall_strobe) begin
                        if (dat_sync && (^{shift, par_bit})) begin
                            oBYTE       <= shift;
                            oBYTE_VALID <= 1'b1;
                        end else begin
                            oFRAME_ERR  <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A strobe in the same cycle keeps the frame alive.
            if (state != IDLE && !fall_strobe && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                state <= IDLE;
            end
        end
    end

    // Key tracker: prefix flags plus the held-key register.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oKEY_CODE <= 8'h00;
            oKEY_EXT  <= 1'b0;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
        end else if (oBYTE_VALID) begin
            case (oBYTE)
                8'hE0: ext_pend <= 1'b1;
                8'hF0: brk_pend <= 1'b1;
                8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: begin
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
                default: begin
                    if (brk_pend) begin
                        if ({ext_pend, oBYTE} == {oKEY_EXT, oKEY_CODE}) begin
                            oKEY_CODE <= 8'h00;
                            oKEY_EXT  <= 1'b0;
                        end
                    end else begin
                        oKEY_CODE <= oBYTE;
                        oKEY_EXT  <= ext_pend;
                    end
                    ext_pend <= 1'b0;
                    brk_pend <= 1'b0;
                end
            endcase
        end
    end

endmodule
